speicher_arbiter: RTL
=====================

# speicher_arbiter

Two-port memory arbiter that shares one single-ported memory between the CPU instruction-fetch port and the CPU data load/store port. It sits between the CPU and memory: request/acknowledge handshakes on the CPU side, one strobe/acknowledge handshake on the memory side. At most one transaction is outstanding at a time. Addresses, write data and read data are registered, so the CPU can treat each port as a private memory.

## Interface
Parameters:
- ADRESS_BREITE, 32, width of all address buses
- DATEN_BREITE, 32, width of all data buses

Ports:
- Clock  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- InstruktionAdresse  in  ADRESS_BREITE  fetch address from CPU
- LeseInstruktion  in  1  fetch request, level, held until InstruktionGeladen
- Instruktion  out  DATEN_BREITE  fetched word, valid with InstruktionGeladen, held until the next fetch completes
- InstruktionGeladen  out  1  one-cycle fetch-done pulse
- DatenAdresse  in  ADRESS_BREITE  load/store address
- DatenRaus  in  DATEN_BREITE  store data from CPU
- LeseDaten  in  1  load request, level
- SchreibeDaten  in  1  store request, level
- DatenRein  out  DATEN_BREITE  loaded word, valid with DatenGeladen, held until the next load completes
- DatenGeladen  out  1  one-cycle load-done pulse
- DatenGespeichert  out  1  one-cycle store-done pulse
- SpeicherAdresse  out  ADRESS_BREITE  memory address, registered
- SpeicherSchreibDaten  out  DATEN_BREITE  memory write data, registered
- SpeicherLeseDaten  in  DATEN_BREITE  memory read data, valid while SpeicherFertig=1
- SpeicherLesen  out  1  memory read strobe, level
- SpeicherSchreiben  out  1  memory write strobe, level
- SpeicherFertig  in  1  memory acknowledge, one cycle
- Belegt  out  1  high whenever state is not LEERLAUF

## Operation
States:
- LEERLAUF: no transaction in flight.
- INSTR: fetch in flight.
- DATEN: load or store in flight.
- ABSCHLUSS: one-cycle recovery.

Transitions:
- LEERLAUF -> INSTR or DATEN when a request is sampled. Address, write data and strobe are registered on the same edge.
- Data port: SchreibeDaten has priority over LeseDaten. If both are high, a store is performed and only DatenGespeichert pulses.
- INSTR/DATEN -> ABSCHLUSS on SpeicherFertig=1. On that edge:
  - the strobe drops;
  - for reads, SpeicherLeseDaten is captured into Instruktion or DatenRein;
  - the matching done pulse is raised for exactly one cycle.
- ABSCHLUSS -> LEERLAUF unconditionally. This gives the requester one cycle to drop its level request, so no request is served twice.
- Simultaneous fetch and data requests in LEERLAUF: resolved per Configuration.
- SpeicherFertig while in LEERLAUF or ABSCHLUSS: ignored, no output change.
- Request inputs and addresses are only sampled in LEERLAUF. Changes while a transaction is in flight are ignored.
- No timeout: INSTR/DATEN wait indefinitely for SpeicherFertig.

Reset values:
- All outputs are 0, including Instruktion, DatenRein, SpeicherAdresse and SpeicherSchreibDaten.
- State is LEERLAUF; round-robin pointer (if compiled in) is "Instruktion zuletzt".
- Reset during a transaction abandons it: strobes are low the next cycle, no done pulse is issued, and any late SpeicherFertig is ignored.

## Timing
- Request high in LEERLAUF at cycle N -> SpeicherLesen/SpeicherSchreiben and SpeicherAdresse valid from cycle N+1.
- SpeicherFertig at cycle M -> done pulse and read data at cycle M+1; strobe low at cycle M+1.
- Next grant: strobe no earlier than M+3 (ABSCHLUSS at M+1, LEERLAUF at M+2).
- Zero-wait memory (SpeicherFertig in the first strobe cycle): 2-cycle request-to-done latency, 3-cycle issue interval.
- Done pulses are never simultaneous. InstruktionGeladen, DatenGeladen and DatenGespeichert are mutually exclusive.
- SpeicherLesen and SpeicherSchreiben are never high together.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined: on a tie in LEERLAUF, the port that was not served last wins.
  - A one-bit "last served" register updates on each grant.
  - After reset, the first tie goes to the data port.
- Not defined: fixed priority, and the data port always wins ties.
  - A fetch is served only when no data request is present in LEERLAUF.
  - The "last served" register is not synthesized.

## Test plan
- Single fetch: InstruktionAdresse=0x10 and LeseInstruktion high at cycle 0, memory acks at cycle 2 with 0xDEADBEEF -> SpeicherLesen=1 with SpeicherAdresse=0x10 at cycles 1-2; InstruktionGeladen=1 and Instruktion=0xDEADBEEF at cycle 3; Belegt=0 at cycle 5.
- Store: DatenAdresse=0x200, DatenRaus=0x12345678, SchreibeDaten held, zero-wait memory -> SpeicherSchreiben=1 for exactly one cycle with those values; one DatenGespeichert pulse; no second write even though the request drops late.
- Tie: LeseInstruktion and LeseDaten rise together after reset, held until served, zero-wait memory:
  - with macro: data, then instruction, then data;
  - without macro: data is served repeatedly while LeseDaten stays high.
- Read and write on data port together: LeseDaten=SchreibeDaten=1 -> only a store is issued, only DatenGespeichert pulses, DatenRein unchanged.
- Reset mid-transaction: Reset at the cycle after a fetch grant, SpeicherFertig one cycle later -> strobe low after reset, no InstruktionGeladen pulse, all outputs 0, Belegt=0.
- Spurious ack: SpeicherFertig=1 while in LEERLAUF with SpeicherLeseDaten=0xFFFFFFFF -> no done pulse, Instruktion and DatenRein unchanged.

Source files
------------

// File: rtl/speicher_arbiter.sv
// Two-port memory arbiter: CPU fetch port and data port share one single-ported memory.
// Optional macro ARBITER_ROUND_ROBIN_EN: round-robin tie-break instead of fixed data priority.
module speicher_arbiter #(
   parameter int ADRESS_BREITE = 32,
   parameter int DATEN_BREITE  = 32
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [ADRESS_BREITE-1:0] InstruktionAdresse,
   input  logic                     LeseInstruktion,
   output logic [DATEN_BREITE-1:0]  Instruktion,
   output logic                     InstruktionGeladen,
   input  logic [ADRESS_BREITE-1:0] DatenAdresse,
   input  logic [DATEN_BREITE-1:0]  DatenRaus,
   input  logic                     LeseDaten,
   input  logic                     SchreibeDaten,
   output logic [DATEN_BREITE-1:0]  DatenRein,
   output logic                     DatenGeladen,
   output logic                     DatenGespeichert,
   output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
   output logic [DATEN_BREITE-1:0]  SpeicherSchreibDaten,
   input  logic [DATEN_BREITE-1:0]  SpeicherLeseDaten,
   output logic                     SpeicherLesen,
   output logic                     SpeicherSchreiben,
   input  logic                     SpeicherFertig,
   output logic                     Belegt
);

   typedef enum logic [1:0] {LEERLAUF, INSTR, DATEN, ABSCHLUSS} zustandT;

   zustandT zustand, naechsterZustand;
   logic    datenAnfrage;
   logic    waehleDaten;
   logic    waehleInstr;

`ifdef ARBITER_ROUND_ROBIN_EN
   logic instrZuletzt;

   // Set means the fetch port was granted last; reset value hands the first tie to data.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         instrZuletzt <= 1'b1;
      end else if (zustand == LEERLAUF) begin
         if (waehleDaten)
            instrZuletzt <= 1'b0;
         else if (waehleInstr)
            instrZuletzt <= 1'b1;
      end
   end

   always_comb begin
      datenAnfrage = LeseDaten | SchreibeDaten;
      waehleDaten  = datenAnfrage & (~LeseInstruktion | instrZuletzt);
      waehleInstr  = LeseInstruktion & ~waehleDaten;
   end
`else
   always_comb begin
      datenAnfrage = LeseDaten | SchreibeDaten;
      waehleDaten  = datenAnfrage;
      waehleInstr  = LeseInstruktion & ~waehleDaten;
   end
`endif

   always_ff @(posedge Clock) begin
      if (Reset)
         zustand <= LEERLAUF;
      else
         zustand <= naechsterZustand;
   end

   always_comb begin
      naechsterZustand = zustand;
      case (zustand)
         LEERLAUF: begin
            if (waehleDaten)
               naechsterZustand = DATEN;
            else if (waehleInstr)
               naechsterZustand = INSTR;
         end
         INSTR, DATEN: begin
            if (SpeicherFertig)
               naechsterZustand = ABSCHLUSS;
         end
         ABSCHLUSS: naechsterZustand = LEERLAUF;
         default:   naechsterZustand = LEERLAUF;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         SpeicherAdresse      <= '0;
         SpeicherSchreibDaten <= '0;
         SpeicherLesen        <= 1'b0;
         SpeicherSchreiben    <= 1'b0;
         Instruktion          <= '0;
         DatenRein            <= '0;
         InstruktionGeladen   <= 1'b0;
         DatenGeladen         <= 1'b0;
         DatenGespeichert     <= 1'b0;
      end else begin
         InstruktionGeladen <= 1'b0;
         DatenGeladen       <= 1'b0;
         DatenGespeichert   <= 1'b0;
         case (zustand)
            LEERLAUF: begin
               if (waehleDaten) begin
                  SpeicherAdresse      <= DatenAdresse;
                  SpeicherSchreibDaten <= DatenRaus;
                  SpeicherSchreiben    <= SchreibeDaten;
                  SpeicherLesen        <= ~SchreibeDaten;
               end else if (waehleInstr) begin
                  SpeicherAdresse <= InstruktionAdresse;
                  SpeicherLesen   <= 1'b1;
               end
            end
            INSTR: begin
               if (SpeicherFertig) begin
                  SpeicherLesen      <= 1'b0;
                  Instruktion        <= SpeicherLeseDaten;
                  InstruktionGeladen <= 1'b1;
               end
            end
            DATEN: begin
               if (SpeicherFertig) begin
                  SpeicherLesen     <= 1'b0;
                  SpeicherSchreiben <= 1'b0;
                  if (SpeicherSchreiben) begin
                     DatenGespeichert <= 1'b1;
                  end else begin
                     DatenRein    <= SpeicherLeseDaten;
                     DatenGeladen <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign Belegt = (zustand != LEERLAUF);

endmodule
